// File: rtl/brick_sequencer.sv
// Game-flow sequencer for the brick-breaker: serve/play/clear/over sequencing,
// score, lives and level bookkeeping, all advanced on pixel-rate enables.
module brick_sequencer #(
    parameter int NUM_BLOCKS   = 8,
    parameter int START_LIVES  = 3,
    parameter int FRAME_LINE   = 480,
    parameter int SERVE_FRAMES = 30,
    parameter int CLEAR_FRAMES = 60
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pixpulse,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    input  logic                  start,
    input  logic                  ball_lost,
    input  logic [NUM_BLOCKS-1:0] broken,
    output logic                  move,
    output logic                  unbreak,
    output logic                  launch,
    output logic [9:0]            score,
    output logic [1:0]            lives,
    output logic [3:0]            level,
    output logic [2:0]            state
);

    localparam int MAX_FRAMES = (SERVE_FRAMES > CLEAR_FRAMES) ? SERVE_FRAMES : CLEAR_FRAMES;
    localparam int CNT_W      = ($clog2(MAX_FRAMES + 1) > 8) ? $clog2(MAX_FRAMES + 1) : 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        CLEAR = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic                    move_q, move_d;
    logic                    unbreak_q, unbreak_d;
    logic                    launch_q, launch_d;
    logic [9:0]              score_q, score_d;
    logic [1:0]              lives_q, lives_d;
    logic [3:0]              level_q, level_d;
    logic [CNT_W-1:0]        frames_q, frames_d;
    logic [NUM_BLOCKS-1:0]   prev_q;

    logic                    frame_tick;
    logic                    all_broken;
    logic                    serve_done;
    logic                    clear_done;
    logic [NUM_BLOCKS-1:0]   new_bits;
    logic [4:0]              rise_cnt;
    logic [10:0]             score_sum;
    logic [9:0]              score_sat;

    assign frame_tick = pixpulse && (hcount == 10'd0) && (vcount == 10'(FRAME_LINE));
    assign all_broken = &broken;
    assign serve_done = frame_tick && (frames_q == CNT_W'(SERVE_FRAMES - 1));
    assign clear_done = frame_tick && (frames_q == CNT_W'(CLEAR_FRAMES - 1));

    // Only rising broken bits score; respawn (1->0) contributes nothing.
    assign new_bits = broken & ~prev_q;

    always_comb begin
        rise_cnt = '0;
        for (int unsigned i = 0; i < NUM_BLOCKS; i++) begin
            rise_cnt = rise_cnt + {4'd0, new_bits[i]};
        end
    end

    assign score_sum = {1'b0, score_q} + {6'd0, rise_cnt};
    assign score_sat = (score_sum > 11'd1023) ? 10'd1023 : score_sum[9:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else if (pixpulse) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, OVER: if (start) state_d = SERVE;
            SERVE:      if (serve_done) state_d = PLAY;
            PLAY: begin
                // Clearing the wall takes priority over a simultaneous lost ball.
                if (all_broken) begin
                    state_d = CLEAR;
                end else if (ball_lost) begin
                    state_d = (lives_q <= 2'd1) ? OVER : SERVE;
                end
            end
            CLEAR:      if (clear_done) state_d = SERVE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        move_d    = 1'b0;
        unbreak_d = 1'b0;
        launch_d  = 1'b0;
        score_d   = score_q;
        lives_d   = lives_q;
        level_d   = level_q;
        frames_d  = frames_q;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    unbreak_d = 1'b1;
                    score_d   = '0;
                    lives_d   = 2'(START_LIVES);
                    level_d   = 4'd1;
                    frames_d  = '0;
                end
            end
            SERVE: begin
                if (frame_tick) frames_d = frames_q + CNT_W'(1);
                if (serve_done) launch_d = 1'b1;
            end
            PLAY: begin
                score_d = score_sat;
                if (all_broken) begin
                    frames_d = '0;
                end else if (ball_lost) begin
                    lives_d  = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                    frames_d = '0;
                end else begin
                    move_d = frame_tick;
                end
            end
            CLEAR: begin
                if (frame_tick) frames_d = frames_q + CNT_W'(1);
                if (clear_done) begin
                    unbreak_d = 1'b1;
                    level_d   = (level_q == 4'd15) ? 4'd15 : level_q + 4'd1;
                    frames_d  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            move_q    <= 1'b0;
            unbreak_q <= 1'b0;
            launch_q  <= 1'b0;
            score_q   <= '0;
            lives_q   <= '0;
            level_q   <= '0;
            frames_q  <= '0;
            prev_q    <= '0;
        end else if (pixpulse) begin
            move_q    <= move_d;
            unbreak_q <= unbreak_d;
            launch_q  <= launch_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            frames_q  <= frames_d;
            prev_q    <= broken;
        end
    end

    assign move    = move_q;
    assign unbreak = unbreak_q;
    assign launch  = launch_q;
    assign score   = score_q;
    assign lives   = lives_q;
    assign level   = level_q;
    assign state   = state_q;

endmodule

// File: doc/brick_sequencer.md
BRICK_SEQUENCER -- requirements
Module: brick_sequencer

Interface
REQ-001 Parameter NUM_BLOCKS, default 8: number of breakable blocks controlled (1..16).
REQ-002 Parameter START_LIVES, default 3: lives loaded at game start (1..3).
REQ-003 Parameter FRAME_LINE, default 480: vcount value marking the frame tick (first blanking line).
REQ-004 Parameter SERVE_FRAMES, default 30: frame ticks spent in SERVE before launch.
REQ-005 Parameter CLEAR_FRAMES, default 60: frame ticks spent in CLEAR before the wall respawns.
REQ-006 clk  input  1  100 MHz system clock; one clock; reset is asynchronous and active-high.
REQ-007 rst  input  1  reset button, asynchronous, active-high.
REQ-008 pixpulse  input  1  one-clock enable every 4 clocks (25 MHz pixel rate).
REQ-009 hcount  input  10  current x pixel; vcount  input  10  current y pixel.
REQ-010 start  input  1  player start button, level-sensitive.
REQ-011 ball_lost  input  1  ball has left the bottom of the screen.
REQ-012 broken  input  NUM_BLOCKS  per-block broken flags from the block instances.
REQ-013 move  output  1  per-frame update strobe to all blocks.
REQ-014 unbreak  output  1  respawn strobe to all blocks.
REQ-015 launch  output  1  serve strobe to the ball.
REQ-016 score  output  10  blocks broken this game; lives  output  2; level  output  4; state  output  3  current FSM state code.

Function
REQ-017 All registers, including outputs, SHALL update only on clk edges where pixpulse=1; every strobe is therefore high for exactly one pixpulse period (4 clk) and is sampled by exactly one downstream pixpulse.
REQ-018 Frame tick SHALL be the pixpulse cycle where hcount=0 and vcount=FRAME_LINE; exactly one per frame.
REQ-019 States and codes: IDLE=0, SERVE=1, PLAY=2, CLEAR=3, OVER=4; codes 5-7 SHALL recover to IDLE on the next pixpulse.
REQ-020 IDLE or OVER with start=1: unbreak strobe, score<=0, lives<=START_LIVES, level<=1, frame counter<=0, go to SERVE; start SHALL be ignored in all other states.
REQ-021 SERVE: count frame ticks; on the SERVE_FRAMES-th tick assert launch strobe and go to PLAY.
REQ-022 PLAY: assert move strobe on every frame tick; move SHALL never be asserted outside PLAY.
REQ-023 PLAY: when all NUM_BLOCKS broken bits are 1, go to CLEAR, counter<=0.
REQ-024 PLAY: ball_lost=1 with at least one block unbroken: lives<=lives-1; if the result is 0 go to OVER, else go to SERVE with counter<=0.
REQ-025 Simultaneous all-broken and ball_lost: CLEAR wins, no life deducted.
REQ-026 CLEAR: on the CLEAR_FRAMES-th frame tick assert unbreak strobe, level<=level+1 saturating at 15, go to SERVE.
REQ-027 OVER: score, lives (=0) and level SHALL hold until start.
REQ-028 Score: a registered copy of broken, prev, SHALL be kept every pixpulse; in PLAY, score SHALL increase by popcount(broken & ~prev) on that pixpulse, saturating at 1023 with no wrap.
REQ-029 Bits falling 1->0 (respawn) SHALL never change score.
REQ-030 Frame counter SHALL be at least 8 bits wide and SHALL reset to 0 on every entry to SERVE or CLEAR.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, move=0, unbreak=0, launch=0, score=0, lives=0, level=0, counter=0, prev=0, independent of clk and pixpulse.
REQ-032 A reset asserted mid-game SHALL abandon the game with no strobe emitted; after release, the block SHALL wait in IDLE for start.

Verification
REQ-033 Reset, start pulse -> unbreak high 4 clk, lives=3, level=1, state=1; launch exactly 30 frame ticks later, state=2.
REQ-034 In PLAY, raise broken bits 0 and 5 in the same pixpulse -> score +2; drop them -> score unchanged; move seen once per frame only.
REQ-035 In PLAY, set broken=8'hFF and ball_lost=1 together -> state=3, lives unchanged; after 60 ticks unbreak strobe, level=2, state=1.
REQ-036 Lose three balls with blocks remaining -> lives 2,1,0, state=4; start -> new game with score=0.
REQ-037 Preload score=1022, break 3 blocks at once -> score=1023; assert rst mid-SERVE -> all outputs 0, no launch.
